// File: rtl/coffee_pkg.sv
// -----------------------------------------------------------------------------
// coffee_pkg
// Shared definitions for the coffee maker brew path:
//   - drink codes (ESPRESSO..MOCHA); codes 0, 6 and 7 are invalid
//   - ingredient valve one-hot constants
//   - brew_sequencer state encoding
//   - recipe step record and a small constructor helper
// No ports (package).
// -----------------------------------------------------------------------------
package coffee_pkg;

    // Drink codes as presented on c_type
    localparam logic [2:0] ESPRESSO   = 3'd1;
    localparam logic [2:0] AMERICANO  = 3'd2;
    localparam logic [2:0] CAPPUCCINO = 3'd3;
    localparam logic [2:0] LATTE      = 3'd4;
    localparam logic [2:0] MOCHA      = 3'd5;

    // Valve enables: [0] coffee, [1] water, [2] milk, [3] chocolate
    localparam logic [3:0] ING_NONE   = 4'b0000;
    localparam logic [3:0] ING_COFFEE = 4'b0001;
    localparam logic [3:0] ING_WATER  = 4'b0010;
    localparam logic [3:0] ING_MILK   = 4'b0100;
    localparam logic [3:0] ING_CHOC   = 4'b1000;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // One recipe step: which valve, how long, and whether it ends the drink
    typedef struct packed {
        logic [3:0] ingredient;
        logic [1:0] length;
        logic       last;
    } recipe_step_t;

    function automatic recipe_step_t mk_step(input logic [3:0] ing,
                                             input logic [1:0] len,
                                             input logic       last);
        recipe_step_t s;
        s.ingredient = ing;
        s.length     = len;
        s.last       = last;
        return s;
    endfunction

    // Entry returned for any unknown (drink, step) pair: no valve, terminates
    localparam recipe_step_t STEP_INVALID = '{ingredient: 4'b0000, length: 2'd0, last: 1'b1};

endpackage

// File: rtl/recipe_rom.sv
// -----------------------------------------------------------------------------
// recipe_rom
// Combinational recipe lookup from (drink code, step index) to a recipe step
// record. Unknown drinks or steps beyond a recipe's end return an all-zero
// entry with last=1 so a sequencer reading it always terminates.
// Ports:
//   i_drink  [2:0]         drink code
//   i_step   [STEP_W-1:0]  0-based step index
//   o_entry  recipe_step_t {ingredient, length, last}
// -----------------------------------------------------------------------------
module recipe_rom
    import coffee_pkg::*;
#(
    parameter int STEP_W = 2
) (
    input  logic [2:0]        i_drink,
    input  logic [STEP_W-1:0] i_step,
    output recipe_step_t      o_entry
);

    int w_idx;

    always_comb begin
        w_idx   = int'(i_step);
        o_entry = STEP_INVALID;
        case (i_drink)
            ESPRESSO: begin
                if (w_idx == 0) o_entry = mk_step(ING_COFFEE, 2'd2, 1'b1);
            end
            AMERICANO: begin
                case (w_idx)
                    0:       o_entry = mk_step(ING_COFFEE, 2'd2, 1'b0);
                    1:       o_entry = mk_step(ING_WATER,  2'd3, 1'b1);
                    default: o_entry = STEP_INVALID;
                endcase
            end
            CAPPUCCINO: begin
                case (w_idx)
                    0:       o_entry = mk_step(ING_COFFEE, 2'd2, 1'b0);
                    1:       o_entry = mk_step(ING_MILK,   2'd1, 1'b1);
                    default: o_entry = STEP_INVALID;
                endcase
            end
            LATTE: begin
                case (w_idx)
                    0:       o_entry = mk_step(ING_COFFEE, 2'd1, 1'b0);
                    1:       o_entry = mk_step(ING_MILK,   2'd3, 1'b1);
                    default: o_entry = STEP_INVALID;
                endcase
            end
            MOCHA: begin
                case (w_idx)
                    0:       o_entry = mk_step(ING_CHOC,   2'd1, 1'b0);
                    1:       o_entry = mk_step(ING_COFFEE, 2'd2, 1'b0);
                    2:       o_entry = mk_step(ING_MILK,   2'd1, 1'b1);
                    default: o_entry = STEP_INVALID;
                endcase
            end
            default: o_entry = STEP_INVALID;
        endcase
    end

endmodule

// File: rtl/brew_sequencer.sv
// -----------------------------------------------------------------------------
// brew_sequencer
// Accepts a confirmed drink selection and walks its recipe one step at a time:
// for each step it opens one valve, pulses start_timer with the step's length
// code, waits for t_expired, then closes the valve for a two-cycle gap
// (GAP, LOAD) before the next step. Sole driver of the dispense timer and
// valve bank. Every output is a register; no input reaches an output
// combinationally.
//
// Handshakes: ok is a valid strobe that is only accepted in IDLE with a drink
// code in 1..5 (the sequencer is "ready" exactly when busy=0); start_timer is
// a one-cycle request to the timer whose completion is t_expired, which is
// only consumed in WAIT; cancel is a level request honoured in any non-IDLE
// state and outranks every other transition.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   c_type [2:0]      drink code, latched on accepted ok
//   ok                confirm pulse
//   cancel            abort request (level)
//   t_expired         timer expiry
//   ing_type [2:0]    drink being brewed, 0 when idle
//   length_time [1:0] duration code of the current step (qualified by start_timer)
//   start_timer       one-cycle timer arm pulse
//   ingredients [3:0] valve enables, at most one set
//   step              current 0-based step index
//   busy              high in every state except IDLE
//   done              one-cycle pulse on recipe completion
//   aborted           one-cycle pulse on cancel
//   o_dbg_state [2:0] current FSM state (debug/observability)
// -----------------------------------------------------------------------------
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter  int MAX_STEPS = 3,
    localparam int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        c_type,
    input  logic              ok,
    input  logic              cancel,
    input  logic              t_expired,
    output logic [2:0]        ing_type,
    output logic [1:0]        length_time,
    output logic              start_timer,
    output logic [3:0]        ingredients,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [2:0]        o_dbg_state
);

    logic [2:0]        r_state;
    logic [2:0]        r_ing_type;
    logic [1:0]        r_length;
    logic              r_start_timer;
    logic [3:0]        r_ingredients;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    logic              w_code_valid;
    recipe_step_t      w_entry;

    assign w_code_valid = (c_type >= ESPRESSO) && (c_type <= MOCHA);

    // The lookup is driven only by registered ing_type/step, which stay
    // stable from LOAD through WAIT, so the same entry serves both the arm
    // decision in LOAD and the last-step decision in WAIT.
    recipe_rom #(
        .STEP_W (STEP_W)
    ) u_recipe_rom (
        .i_drink (r_ing_type),
        .i_step  (r_step),
        .o_entry (w_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ing_type    <= 3'd0;
            r_length      <= 2'd0;
            r_start_timer <= 1'b0;
            r_ingredients <= ING_NONE;
            r_step        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            r_start_timer <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;

            if ((r_state != ST_IDLE) && cancel) begin
                r_state       <= ST_IDLE;
                r_ingredients <= ING_NONE;
                r_ing_type    <= 3'd0;
                r_busy        <= 1'b0;
                r_aborted     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ok && w_code_valid) begin
                            r_ing_type <= c_type;
                            r_step     <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        // Registering here makes valve and start_timer rise
                        // together in the ARM cycle.
                        r_start_timer <= 1'b1;
                        r_length      <= w_entry.length;
                        r_ingredients <= w_entry.ingredient;
                        r_state       <= ST_ARM;
                    end
                    ST_ARM: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (t_expired) begin
                            r_ingredients <= ING_NONE;
                            if (w_entry.last) begin
                                r_done     <= 1'b1;
                                r_ing_type <= 3'd0;
                                r_state    <= ST_DONE;
                            end else begin
                                r_step  <= r_step + STEP_W'(1);
                                r_state <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        r_state <= ST_LOAD;
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_ingredients <= ING_NONE;
                        r_ing_type    <= 3'd0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ing_type    = r_ing_type;
    assign length_time = r_length;
    assign start_timer = r_start_timer;
    assign ingredients = r_ingredients;
    assign step        = r_step;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign o_dbg_state = r_state;

endmodule

// File: doc/brew_sequencer.md
# brew_sequencer

Recipe sequencer for the coffee maker: accepts a confirmed drink selection, then steps through that drink's ingredient recipe one step at a time. For each step it opens the matching ingredient valve, arms the shared dispense timer with the step's duration code, and waits for expiry. It sits between the user-selection front end and the single dispense timer/valve bank, and is their only driver.

## Interface
Parameters:
- MAX_STEPS, 3: maximum recipe steps per drink; sets the width of `step`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- c_type  in  3  drink code: 1 espresso, 2 americano, 3 cappuccino, 4 latte, 5 mocha. Codes 0, 6 and 7 are invalid.
- ok  in  1  confirm pulse from the front end.
- cancel  in  1  abort request; level-sensitive.
- t_expired  in  1  shared timer expiry; high for at least one cycle.
- ing_type  out  3  latched drink code of the brew in progress; 0 when idle.
- length_time  out  2  timer duration code for the current step.
- start_timer  out  1  one-cycle pulse that arms the timer.
- ingredients  out  4  valve enables: [0] coffee, [1] water, [2] milk, [3] chocolate. At most one bit is set.
- step  out  2  index of the current step (0-based).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a recipe completes.
- aborted  out  1  one-cycle pulse when a brew is cancelled.

## Operation
Recipes, written as {ingredient, length code} per step:
- 1 espresso: {coffee,2}.
- 2 americano: {coffee,2}, {water,3}.
- 3 cappuccino: {coffee,2}, {milk,1}.
- 4 latte: {coffee,1}, {milk,3}.
- 5 mocha: {chocolate,1}, {coffee,2}, {milk,1}.

States and transitions:
- IDLE: when `ok` is high and `c_type` is in 1..5, latch `c_type` into `ing_type`, clear `step`, go to LOAD. `ok` with an invalid code is ignored.
- LOAD: fetch recipe entry (`ing_type`, `step`), go to ARM.
- ARM: `start_timer`=1, drive `length_time`, drive the step's valve bit, go to WAIT. `t_expired` is ignored in ARM.
- WAIT: hold the valve bit. On `t_expired`: if this is the last step go to DONE, otherwise increment `step` and go to GAP.
- GAP: all valves off for one cycle (break-before-make), go to LOAD.
- DONE: `done`=1, valves off, `ing_type` cleared, go to IDLE.

Further rules:
- `cancel` high in any non-IDLE state has priority over all other transitions. It forces IDLE on the next edge, with valves off, `ing_type`=0, and `aborted`=1 for that cycle.
- `cancel` in IDLE is a no-op.
- `ok` while busy is ignored; a changing `c_type` while busy has no effect.
- `length_time` holds its value outside ARM/WAIT; only `start_timer` qualifies it.
- `step` never exceeds the recipe length minus 1.

## Timing
- Reset (synchronous): state IDLE; `ing_type`=0, `length_time`=0, `start_timer`=0, `ingredients`=0, `step`=0, `busy`=0, `done`=0, `aborted`=0. Reset mid-brew clears the valves on the same edge.
- `ok` sampled high at edge k: LOAD in cycle k+1, ARM in cycle k+2 (`start_timer` and valve rise together), WAIT from cycle k+3.
- `t_expired` sampled in WAIT at edge j:
  - Non-final step: valve off in cycle j+1 (GAP), then LOAD at j+2, next ARM at j+3.
  - Final step: DONE in cycle j+1, IDLE at j+2.
- Minimum inter-step valve-off time is 2 cycles (GAP, LOAD).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `cancel` and `t_expired` sampled high on the same edge in WAIT: `cancel` wins.

## Structure
- Shared package `coffee_pkg` holds:
  - drink code constants (ESPRESSO..MOCHA);
  - ingredient bit constants (ING_COFFEE, ING_WATER, ING_MILK, ING_CHOC);
  - state encoding;
  - recipe step record {ingredient[3:0], length[1:0], last}.
- Sub-module `recipe_rom`: combinational lookup from (drink code, step) to a recipe step record. Invalid inputs return all-zero with `last`=1.
- `brew_sequencer` holds the FSM, the step counter and the output registers.

## Test plan
- Reset, then `ok` with `c_type`=1: `start_timer` pulses in cycle 2 with `length_time`=2 and `ingredients`=0001. With `t_expired` at cycle 10: `done` in cycle 11, `busy`=0 in cycle 12.
- Mocha: ARM sequence is 1000/len1, 0001/len2, 0100/len1. `ingredients`=0000 in each GAP cycle, and exactly one `done`.
- `ok` with `c_type`=0, 6 and 7: state stays IDLE, `busy`=0, no `start_timer`.
- Latte in WAIT of step 1: assert `cancel` together with `t_expired`. Required: `aborted`=1 next cycle, `ingredients`=0, `ing_type`=0, no `done`.
- Americano: pulse `ok` and change `c_type` to 4 mid-brew. Recipe stays americano, `ing_type`=2 throughout.
- Assert `rst` during WAIT of a cappuccino: all outputs zero on the next edge. A following `ok` starts a fresh brew from step 0.
